c128_key_matrix: RTL and testbench
==================================

// Module: c128_key_matrix
// PURPOSE
//  Keyboard/joystick matrix directly upstream of CIA1: consumes CIA1 pa_out/pb_out plus the VIC K0-K2
//  lines, produces CIA1 pa_in/pb_in. Key state comes from a toggle-strobed event bus from the HID
//  mapper. Enforces a minimum key hold so fast taps survive the KERNAL scan. Emits RESTORE level and
//  the latching CAPS LOCK and 40/80 switch states.
// PARAMETERS
//  TICK_DIV    327680  clk cycles per hold tick (10 ms at 32.7 MHz); counter is 20 bits, range 2..2^20
//  HOLD_TICKS  2       min ticks a pressed key stays down after its release event; range 1..3
// PORTS
//  clk         in   1   system clock; all state on posedge
//  res_n       in   1   asynchronous active-low reset
//  key_evt     in   9   [8] toggle, [7] 1=press 0=release, [6:0] key id
//  clear_all   in   1   level; release every matrix key immediately (focus loss)
//  pa_out      in   8   CIA1 port A drive (1 = not driven low)
//  pb_out      in   8   CIA1 port B drive (1 = not driven low)
//  k_out       in   3   VIC extended row drive K0-K2 (1 = not driven low)
//  joy1_n      in   5   port-1 joystick, active low {fire,right,left,down,up}
//  joy2_n      in   5   port-2 joystick, active low, same order
//  pa_in       out  8   to CIA1 port A input
//  pb_in       out  8   to CIA1 port B input
//  restore_n   out  1   low while RESTORE held (to NMI logic)
//  caps_n      out  1   CAPS LOCK latch, low = locked
//  col80_n     out  1   40/80 latch, low = 80 column
// BEHAVIOUR
//  Reset (async): all keys released, hold counters 0, last toggle 0, tick counter 0, pa_in=pb_in=FF,
//   restore_n=1, caps_n=1, col80_n=1.
//  Key ids: id[6:3]=row, id[2:0]=col. Rows 0-7 -> PA bit row; rows 8-10 -> K0-K2; col -> PB bit.
//   Row 11: col0 RESTORE, col1 40/80, col2 CAPS LOCK. Ids >= 0x5B ignored (no state change).
//  Event accept: key_evt[8] != registered last toggle; last toggle updated same cycle. One event per
//   cycle max; key state/latch changes visible on the clk after acceptance.
//  Per matrix key (88): pressed bit, release_pending bit, 2-bit hold counter.
//   press event: pressed=1, release_pending=0, hold=HOLD_TICKS.
//   release event: if hold==0 pressed=0 at once, else release_pending=1.
//   tick (tick counter wraps at TICK_DIV-1, 1-cycle pulse): hold>0 -> hold-1; when hold==0 and
//    release_pending -> pressed=0, release_pending=0 (i.e. release lands 0..1 tick after hold expires).
//   press after pending release cancels the pending release and reloads hold.
//  clear_all: all pressed/pending/hold zeroed that cycle; an event accepted in the same cycle is
//   dropped (toggle still consumed). RESTORE/latches unaffected.
//  RESTORE: restore_n = ~held, no hold extension, follows press/release directly.
//  CAPS LOCK, 40/80: each press event toggles latch; release events ignored.
//  Matrix (single-level, no ghost expansion), computed from registered key state, output registered
//   (1 clk latency from pa_out/pb_out/k_out/joy change):
//   pb_in[c] = ~(OR over r of key[r][c] & rowlow[r]) & joy1_n[c] (c<5; bits 7:5 no joystick)
//    rowlow[r] = ~pa_out[r] (r<8), ~k_out[r-8] (r 8-10)
//   pa_in[r] = pa_out[r] & ~(OR over c of key[r][c] & ~pb_out[c]) & joy2_n[r] (r<5)
//   K rows do not feed back to pa_in.
//  Key state changes mid-scan are allowed; no sampling relative to CIA phi2.
//  Reset mid-hold discards all pending releases.
// TESTING
//  Tap: press id 0x0A (row1 col2) then release 1 clk later, pa_out=FD, pb_out=FF -> pb_in=FB
//   for >= HOLD_TICKS*TICK_DIV clks, FF after <= (HOLD_TICKS+1)*TICK_DIV.
//  Reverse path: key 0x0A held, pa_out=FF, pb_out=FB -> pa_in=FD; pb_out=FF -> pa_in=FF.
//  K row: id 0x41 held, k_out=6, pa_out=FF -> pb_in=FD; k_out=7 -> FF; pa_in stays FF.
//  Latches: three CAPS press events (0x5A) -> caps_n 0,1,0; releases leave it; 0x58 -> restore_n
//   low while held, high 1 clk after release.
//  Toggle handling: key_evt held constant 100 clks after one event -> single state change; id 0x5F
//   press -> no output change.
//  clear_all with keys 0x00,0x3F held and simultaneous press of 0x07 -> all released, pb_in=FF with
//   pa_out=00; async res_n pulse mid-hold -> outputs reset values immediately.

Source files
------------

// File: rtl/c128_key_matrix.sv
// C128 keyboard/joystick matrix feeding CIA1 port inputs, driven by a toggle-strobed key event bus.
// Each matrix key is kept down for a minimum number of hold ticks so short taps survive a KERNAL scan.
module c128_key_matrix #(
  parameter int TICK_DIV   = 327680,
  parameter int HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [8:0] key_evt,
  input  logic       clear_all,
  input  logic [7:0] pa_out,
  input  logic [7:0] pb_out,
  input  logic [2:0] k_out,
  input  logic [4:0] joy1_n,
  input  logic [4:0] joy2_n,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       caps_n,
  output logic       col80_n
);

  localparam int         NKEYS      = 88;
  localparam logic [19:0] TICK_LAST  = 20'(TICK_DIV - 1);
  localparam logic [1:0]  HOLD_INIT  = 2'(HOLD_TICKS);
  localparam logic [6:0]  ID_RESTORE = 7'h58;
  localparam logic [6:0]  ID_COL80   = 7'h59;
  localparam logic [6:0]  ID_CAPS    = 7'h5A;

  logic [19:0]      tick_cnt;
  logic             tick;
  logic             last_tog;
  logic             evt_acc;
  logic             evt_press;
  logic [6:0]       evt_id;
  logic             evt_matrix;
  logic [NKEYS-1:0] pressed, pressed_nx;
  logic [NKEYS-1:0] pending, pending_nx;
  logic [1:0]       hold    [NKEYS];
  logic [1:0]       hold_nx [NKEYS];
  logic [7:0]       pa_nx, pb_nx;

  assign tick       = (tick_cnt == TICK_LAST);
  assign evt_acc    = key_evt[8] ^ last_tog;
  assign evt_press  = key_evt[7];
  assign evt_id     = key_evt[6:0];
  assign evt_matrix = (evt_id < 7'(NKEYS));

  // Tick ageing first; an event on the same key then overrides, using the pre-tick hold count.
  always_comb begin
    pressed_nx = pressed;
    pending_nx = pending;
    hold_nx    = hold;
    if (tick) begin
      for (int k = 0; k < NKEYS; k++) begin
        if (hold[k] != 2'd0) begin
          hold_nx[k] = hold[k] - 2'd1;
        end else if (pending[k]) begin
          pressed_nx[k] = 1'b0;
          pending_nx[k] = 1'b0;
        end
      end
    end
    if (evt_acc && evt_matrix) begin
      if (evt_press) begin
        pressed_nx[evt_id] = 1'b1;
        pending_nx[evt_id] = 1'b0;
        hold_nx[evt_id]    = HOLD_INIT;
      end else if (hold[evt_id] == 2'd0) begin
        pressed_nx[evt_id] = 1'b0;
        pending_nx[evt_id] = 1'b0;
      end else begin
        pending_nx[evt_id] = 1'b1;
      end
    end
    if (clear_all) begin
      pressed_nx = '0;
      pending_nx = '0;
      for (int k = 0; k < NKEYS; k++) hold_nx[k] = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pressed <= '0;
      pending <= '0;
      for (int k = 0; k < NKEYS; k++) hold[k] <= 2'd0;
    end else begin
      pressed <= pressed_nx;
      pending <= pending_nx;
      hold    <= hold_nx;
    end
  end

  // K rows only pull port B; they have no path back onto port A.
  always_comb begin
    pb_nx = 8'hFF;
    pa_nx = pa_out;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (pressed[r*8+c]) begin
          if (!pa_out[r]) pb_nx[c] = 1'b0;
          if (!pb_out[c]) pa_nx[r] = 1'b0;
        end
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (pressed[(r+8)*8+c] && !k_out[r]) pb_nx[c] = 1'b0;
      end
    end
    pb_nx[4:0] = pb_nx[4:0] & joy1_n;
    pa_nx[4:0] = pa_nx[4:0] & joy2_n;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      last_tog  <= 1'b0;
      tick_cnt  <= '0;
      pa_in     <= 8'hFF;
      pb_in     <= 8'hFF;
      restore_n <= 1'b1;
      caps_n    <= 1'b1;
      col80_n   <= 1'b1;
    end else begin
      last_tog <= key_evt[8];
      tick_cnt <= tick ? 20'd0 : tick_cnt + 20'd1;
      pa_in    <= pa_nx;
      pb_in    <= pb_nx;
      if (evt_acc && !clear_all) begin
        case (evt_id)
          ID_RESTORE: restore_n <= ~evt_press;
          ID_COL80:   if (evt_press) col80_n <= ~col80_n;
          ID_CAPS:    if (evt_press) caps_n <= ~caps_n;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c128_key_matrix.sv
// Self-checking bench for c128_key_matrix: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a per-key behavioural model.
module tb_c128_key_matrix;

  localparam int TDIV = 6;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [8:0] key_evt = '0;
  logic       clear_all = 1'b0;
  logic [7:0] pa_out = 8'hFF, pb_out = 8'hFF;
  logic [2:0] k_out = 3'h7;
  logic [4:0] joy1_n = 5'h1F, joy2_n = 5'h1F;
  logic [7:0] pa_in, pb_in;
  logic       restore_n, caps_n, col80_n;

  int   checks = 0;
  int   errors = 0;
  logic tog = 1'b0;

  c128_key_matrix #(.TICK_DIV(TDIV), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .res_n(res_n), .key_evt(key_evt), .clear_all(clear_all),
    .pa_out(pa_out), .pb_out(pb_out), .k_out(k_out), .joy1_n(joy1_n), .joy2_n(joy2_n),
    .pa_in(pa_in), .pb_in(pb_in), .restore_n(restore_n), .caps_n(caps_n), .col80_n(col80_n)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-key down/pending flags and remaining hold ticks.
  bit         m_down [88];
  bit         m_pend [88];
  int         m_hold [88];
  int         m_tcnt;
  bit         m_last;
  logic [7:0] exp_pa, exp_pb;
  logic       exp_restore_n, exp_caps_n, exp_col80_n;

  task automatic model_reset();
    for (int k = 0; k < 88; k++) begin
      m_down[k] = 0; m_pend[k] = 0; m_hold[k] = 0;
    end
    m_tcnt = 0; m_last = 0;
    exp_pa = 8'hFF; exp_pb = 8'hFF;
    exp_restore_n = 1'b1; exp_caps_n = 1'b1; exp_col80_n = 1'b1;
  endtask

  task automatic model_step();
    logic [7:0] npa, npb;
    bit tick, acc, press;
    int id, row, col, hold_before;
    npa = pa_out;
    npb = 8'hFF;
    for (int k = 0; k < 88; k++) begin
      if (m_down[k]) begin
        row = k / 8;
        col = k % 8;
        if (row < 8) begin
          if (pa_out[row] == 1'b0) npb[col] = 1'b0;
          if (pb_out[col] == 1'b0) npa[row] = 1'b0;
        end else if (k_out[row-8] == 1'b0) begin
          npb[col] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (!joy1_n[i]) npb[i] = 1'b0;
      if (!joy2_n[i]) npa[i] = 1'b0;
    end
    exp_pa = npa;
    exp_pb = npb;
    tick   = (m_tcnt == TDIV - 1);
    m_tcnt = tick ? 0 : m_tcnt + 1;
    acc    = (key_evt[8] != m_last);
    m_last = key_evt[8];
    id     = int'(key_evt[6:0]);
    press  = key_evt[7];
    hold_before = (id < 88) ? m_hold[id] : 0;
    if (tick) begin
      for (int k = 0; k < 88; k++) begin
        if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
        else if (m_pend[k]) begin m_down[k] = 0; m_pend[k] = 0; end
      end
    end
    if (clear_all) begin
      for (int k = 0; k < 88; k++) begin
        m_down[k] = 0; m_pend[k] = 0; m_hold[k] = 0;
      end
    end else if (acc) begin
      if (id < 88) begin
        if (press) begin
          m_down[id] = 1; m_pend[id] = 0; m_hold[id] = HOLD;
        end else if (hold_before == 0) begin
          m_down[id] = 0; m_pend[id] = 0;
        end else begin
          m_pend[id] = 1;
        end
      end else if (id == 'h58) exp_restore_n = ~press;
      else if (id == 'h59 && press) exp_col80_n = ~exp_col80_n;
      else if (id == 'h5A && press) exp_caps_n = ~exp_caps_n;
    end
  endtask

  always @(posedge clk or negedge res_n) begin
    if (!res_n) model_reset();
    else model_step();
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      checkOutput("model_pa_in", pa_in, exp_pa);
      checkOutput("model_pb_in", pb_in, exp_pb);
      checkOutput("model_restore_n", {7'd0, restore_n}, {7'd0, exp_restore_n});
      checkOutput("model_caps_n", {7'd0, caps_n}, {7'd0, exp_caps_n});
      checkOutput("model_col80_n", {7'd0, col80_n}, {7'd0, exp_col80_n});
    end
  end

  task automatic applyStimulus(input logic [7:0] pa, input logic [7:0] pb, input logic [2:0] k,
                               input logic [4:0] j1, input logic [4:0] j2);
    pa_out = pa; pb_out = pb; k_out = k; joy1_n = j1; joy2_n = j2;
  endtask

  task automatic send_evt(input logic press, input logic [6:0] id);
    tog = ~tog;
    key_evt = {tog, press, id};
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int fb_count;

  initial begin
    wait_cycles(3);
    res_n = 1'b1;
    wait_cycles(1);
    checkOutput("reset_pa_in", pa_in, 8'hFF);
    checkOutput("reset_pb_in", pb_in, 8'hFF);
    checkOutput("reset_restore_n", {7'd0, restore_n}, 8'd1);
    checkOutput("reset_caps_n", {7'd0, caps_n}, 8'd1);
    checkOutput("reset_col80_n", {7'd0, col80_n}, 8'd1);

    // Tap: press then release one clock later; hold must stretch the key.
    applyStimulus(8'hFD, 8'hFF, 3'h7, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h0A);
    wait_cycles(1);
    send_evt(1'b0, 7'h0A);
    fb_count = 0;
    for (int i = 0; i < 40; i++) begin
      wait_cycles(1);
      if (pb_in == 8'hFB) fb_count++;
    end
    checks++;
    if (fb_count < HOLD * TDIV || fb_count > (HOLD + 1) * TDIV + 1) begin
      errors++;
      $display("[TB] FAIL tap_hold: got %0d cycles low expected %0d..%0d", fb_count,
               HOLD * TDIV, (HOLD + 1) * TDIV + 1);
    end
    checkOutput("tap_released", pb_in, 8'hFF);

    // Reverse path via port A.
    applyStimulus(8'hFF, 8'hFB, 3'h7, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h0A);
    wait_cycles(3);
    checkOutput("reverse_pa_low", pa_in, 8'hFD);
    applyStimulus(8'hFF, 8'hFF, 3'h7, 5'h1F, 5'h1F);
    wait_cycles(2);
    checkOutput("reverse_pa_high", pa_in, 8'hFF);
    send_evt(1'b0, 7'h0A);
    wait_cycles(25);

    // K row key 0x41.
    applyStimulus(8'hFF, 8'hFF, 3'h6, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h41);
    wait_cycles(3);
    checkOutput("krow_pb_low", pb_in, 8'hFD);
    checkOutput("krow_pa_idle", pa_in, 8'hFF);
    k_out = 3'h7;
    wait_cycles(2);
    checkOutput("krow_pb_high", pb_in, 8'hFF);
    send_evt(1'b0, 7'h41);
    wait_cycles(25);

    // CAPS LOCK latch toggles on presses only.
    for (int i = 0; i < 3; i++) begin
      send_evt(1'b1, 7'h5A);
      wait_cycles(2);
      checkOutput("caps_press", {7'd0, caps_n}, (i % 2 == 0) ? 8'd0 : 8'd1);
      send_evt(1'b0, 7'h5A);
      wait_cycles(2);
      checkOutput("caps_release", {7'd0, caps_n}, (i % 2 == 0) ? 8'd0 : 8'd1);
    end

    // RESTORE follows press/release with no hold.
    send_evt(1'b1, 7'h58);
    wait_cycles(1);
    checkOutput("restore_low", {7'd0, restore_n}, 8'd0);
    send_evt(1'b0, 7'h58);
    wait_cycles(1);
    checkOutput("restore_high", {7'd0, restore_n}, 8'd1);

    // A held toggle level must be consumed only once.
    send_evt(1'b1, 7'h5A);
    wait_cycles(100);
    checkOutput("toggle_single", {7'd0, caps_n}, 8'd1);

    // Unused id 0x5F changes nothing.
    applyStimulus(8'h00, 8'h00, 3'h0, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h5F);
    wait_cycles(3);
    checkOutput("id5f_pb", pb_in, 8'hFF);
    checkOutput("id5f_pa", pa_in, 8'h00);
    checkOutput("id5f_caps", {7'd0, caps_n}, 8'd1);

    // clear_all drops held keys and a simultaneous press.
    applyStimulus(8'h00, 8'hFF, 3'h7, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h00);
    wait_cycles(1);
    send_evt(1'b1, 7'h3F);
    wait_cycles(3);
    checkOutput("clear_before", pb_in, 8'h7E);
    clear_all = 1'b1;
    send_evt(1'b1, 7'h07);
    wait_cycles(1);
    clear_all = 1'b0;
    wait_cycles(3);
    checkOutput("clear_after", pb_in, 8'hFF);

    // Async reset mid-hold.
    applyStimulus(8'hFD, 8'hFF, 3'h7, 5'h1F, 5'h1F);
    send_evt(1'b1, 7'h0A);
    wait_cycles(1);
    send_evt(1'b0, 7'h0A);
    wait_cycles(1);
    send_evt(1'b1, 7'h5A);
    wait_cycles(2);
    checkOutput("prereset_pb", pb_in, 8'hFB);
    checkOutput("prereset_caps", {7'd0, caps_n}, 8'd0);
    #2 res_n = 1'b0;
    #1;
    checkOutput("async_pb", pb_in, 8'hFF);
    checkOutput("async_pa", pa_in, 8'hFF);
    checkOutput("async_caps", {7'd0, caps_n}, 8'd1);
    checkOutput("async_restore", {7'd0, restore_n}, 8'd1);
    key_evt = '0;
    tog = 1'b0;
    wait_cycles(1);
    res_n = 1'b1;
    wait_cycles(2);
    checkOutput("postreset_pb", pb_in, 8'hFF);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      if (i % 4 == 0) begin
        applyStimulus(8'($urandom), 8'($urandom), 3'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F,
                      ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F);
      end
      clear_all = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) == 0) send_evt(1'($urandom), 7'($urandom_range(8'h58, 8'h5F)));
        else send_evt(1'($urandom), 7'($urandom_range(0, 87)));
      end
      wait_cycles(1);
    end
    clear_all = 1'b0;
    wait_cycles(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
